servo_gate_sequencer: RTL and testbench

Controller for the warehouse gate servo. Decodes position codes (1–16) and storage codes (103–113) from the UART receive byte stream, checks the pair against the allowed bin map, and sequences the servo through open, hold and close phases. Generates a glitch-free 20 ms-frame PWM whose pulse width changes only on frame boundaries. Sits between the UART receiver and the servo pin, replacing free-running pulse selection with a handshaked, frame-aligned sequence.

---
 rtl/servo_gate_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_servo_gate_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_gate_sequencer.sv
// servo_gate_sequencer: gate servo controller.
// Pairs a position byte (1..16) with a storage byte (103..113) from the UART stream.
// It checks the pair against the bin map, then runs the servo through ARM, OPEN
// and SETTLE. The PWM output has a fixed frame length, and its pulse width is
// only reloaded on frame boundaries.
// Optional feature macro: SERVO_SEQ_TIMEOUT_EN. When defined, a partial pair
// (only one of the two codes received) is discarded after TIMEOUT_FRAMES
// frames, and err pulses.
module servo_gate_sequencer #(
    parameter int FRAME_CYCLES   = 1000000,
    parameter int PW_CLOSED      = 110000,
    parameter int PW_OPEN        = 35000,
    parameter int HOLD_FRAMES    = 100,
    parameter int SETTLE_FRAMES  = 25,
    parameter int TIMEOUT_FRAMES = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       servo,
    output logic       busy,
    output logic       gate_open,
    output logic       err,
    output logic       drop
);

    // The frame counter is sized to cover every frame-count parameter,
    // with a minimum width of 8 bits.
    localparam int FMAX1 = (HOLD_FRAMES > SETTLE_FRAMES) ? HOLD_FRAMES : SETTLE_FRAMES;
    localparam int FMAX  = (FMAX1 > TIMEOUT_FRAMES) ? FMAX1 : TIMEOUT_FRAMES;
    localparam int HW    = ($clog2(FMAX + 1) > 8) ? $clog2(FMAX + 1) : 8;

    localparam logic [19:0]   FRAME_LAST  = 20'(FRAME_CYCLES - 1);
    localparam logic [19:0]   PW_OPEN_W   = 20'(PW_OPEN);
    localparam logic [19:0]   PW_CLOSED_W = 20'(PW_CLOSED);
    localparam logic [19:0]   CNT_ONE     = 20'd1;
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_FRAMES - 1);
    localparam logic [HW-1:0] SETTLE_LAST = HW'(SETTLE_FRAMES - 1);
    localparam logic [HW-1:0] H_ONE       = HW'(1);
`ifdef SERVO_SEQ_TIMEOUT_EN
    localparam logic [HW-1:0] TO_LAST     = HW'(TIMEOUT_FRAMES - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_OPEN,
        S_SETTLE
    } state_t;

    state_t        state_reg, state_next;
    logic [19:0]   cnt_reg;
    logic [19:0]   pw_active_reg;
    logic          servo_reg;
    logic [7:0]    pos_reg, pos_next;
    logic [7:0]    sto_reg, sto_next;
    logic          pos_v_reg, pos_v_next;
    logic          sto_v_reg, sto_v_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic          err_reg, err_next;
    logic          drop_reg, drop_next;
`ifdef SERVO_SEQ_TIMEOUT_EN
    logic [HW-1:0] to_cnt_reg, to_cnt_next;
`endif

    logic frame_tick;
    logic is_pos;
    logic is_sto;
    logic sto_allowed;
    logic pair_ok;

    assign frame_tick = (cnt_reg == FRAME_LAST);
    assign is_pos     = (rx_data >= 8'd1) && (rx_data <= 8'd16);
    assign is_sto     = (rx_data >= 8'd103) && (rx_data <= 8'd113);
    assign pair_ok    = sto_allowed && (pos_reg == (sto_reg - 8'd100));

    // Bin map: storage codes 106 and 110 have no bin.
    always_comb begin
        sto_allowed = 1'b0;
        case (sto_reg)
            8'd103, 8'd104, 8'd105,
            8'd107, 8'd108, 8'd109,
            8'd111, 8'd112, 8'd113: sto_allowed = 1'b1;
            default:                sto_allowed = 1'b0;
        endcase
    end

    // Free-running PWM frame counter, with pulse width reloaded only at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            pw_active_reg <= PW_CLOSED_W;
            servo_reg     <= 1'b0;
        end else begin
            cnt_reg   <= frame_tick ? '0 : cnt_reg + CNT_ONE;
            servo_reg <= (cnt_reg < pw_active_reg);
            if (frame_tick) begin
                if ((state_reg == S_ARM) ||
                    ((state_reg == S_OPEN) && (hold_cnt_reg < HOLD_LAST)))
                    pw_active_reg <= PW_OPEN_W;
                else
                    pw_active_reg <= PW_CLOSED_W;
            end
        end
    end

    // Sequencer state and code registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            pos_reg      <= '0;
            sto_reg      <= '0;
            pos_v_reg    <= 1'b0;
            sto_v_reg    <= 1'b0;
            hold_cnt_reg <= '0;
            err_reg      <= 1'b0;
            drop_reg     <= 1'b0;
`ifdef SERVO_SEQ_TIMEOUT_EN
            to_cnt_reg   <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            pos_reg      <= pos_next;
            sto_reg      <= sto_next;
            pos_v_reg    <= pos_v_next;
            sto_v_reg    <= sto_v_next;
            hold_cnt_reg <= hold_cnt_next;
            err_reg      <= err_next;
            drop_reg     <= drop_next;
`ifdef SERVO_SEQ_TIMEOUT_EN
            to_cnt_reg   <= to_cnt_next;
`endif
        end
    end

    // Next-state logic: byte capture, pair check, and phase sequencing.
    // While a complete pair is being checked, the check takes priority, and a
    // byte arriving in that same cycle is not captured.
    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        sto_next   = sto_reg;
        pos_v_next = pos_v_reg;
        sto_v_next = sto_v_reg;
        err_next   = 1'b0;
        drop_next  = rx_valid && (state_reg != S_IDLE);
`ifdef SERVO_SEQ_TIMEOUT_EN
        to_cnt_next = '0;
`endif

        case (state_reg)
            S_IDLE: begin
                if (pos_v_reg && sto_v_reg) begin
                    if (pair_ok) begin
                        state_next = S_ARM;
                    end else begin
                        err_next   = 1'b1;
                        pos_v_next = 1'b0;
                        sto_v_next = 1'b0;
                    end
                end else begin
                    if (rx_valid && is_pos) begin
                        pos_next   = rx_data;
                        pos_v_next = 1'b1;
                    end else if (rx_valid && is_sto) begin
                        sto_next   = rx_data;
                        sto_v_next = 1'b1;
                    end
`ifdef SERVO_SEQ_TIMEOUT_EN
                    if (rx_valid && (is_pos || is_sto)) begin
                        to_cnt_next = '0;
                    end else if (pos_v_reg ^ sto_v_reg) begin
                        to_cnt_next = to_cnt_reg;
                        if (frame_tick) begin
                            if (to_cnt_reg == TO_LAST) begin
                                to_cnt_next = '0;
                                pos_v_next  = 1'b0;
                                sto_v_next  = 1'b0;
                                err_next    = 1'b1;
                            end else begin
                                to_cnt_next = to_cnt_reg + H_ONE;
                            end
                        end
                    end
`endif
                end
            end
            S_ARM: begin
                if (frame_tick)
                    state_next = S_OPEN;
            end
            S_OPEN: begin
                if (frame_tick && (hold_cnt_reg == HOLD_LAST))
                    state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (frame_tick && (hold_cnt_reg == SETTLE_LAST)) begin
                    state_next = S_IDLE;
                    pos_v_next = 1'b0;
                    sto_v_next = 1'b0;
                end
            end
            default: state_next = S_IDLE;
        endcase

        hold_cnt_next = hold_cnt_reg;
        if (state_next != state_reg)
            hold_cnt_next = '0;
        else if (frame_tick && ((state_reg == S_OPEN) || (state_reg == S_SETTLE)))
            hold_cnt_next = hold_cnt_reg + H_ONE;
    end

    // Output drive. busy and gate_open decode the registered state directly.
    assign servo     = servo_reg;
    assign busy      = (state_reg != S_IDLE);
    assign gate_open = (state_reg == S_OPEN);
    assign err       = err_reg;
    assign drop      = drop_reg;

endmodule

// File: tb/tb_servo_gate_sequencer.sv
// Directed testbench for servo_gate_sequencer using small frame parameters.
// Set SERVO_SEQ_TIMEOUT_EN to exercise the partial-pair timeout.
module tb_servo_gate_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       servo, busy, gate_open, err, drop;

    servo_gate_sequencer #(
        .FRAME_CYCLES  (100),
        .PW_CLOSED     (30),
        .PW_OPEN       (10),
        .HOLD_FRAMES   (3),
        .SETTLE_FRAMES (2),
        .TIMEOUT_FRAMES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .servo    (servo),
        .busy     (busy),
        .gate_open(gate_open),
        .err      (err),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Monitor statistics, sampled on the falling edge.
    int pw_q[$];
    int run = 0;
    int cyc = 0;
    int err_cnt = 0, drop_cnt = 0, go_cyc = 0, go_rise = 0, busy_cyc = 0;
    int go_fall_cyc = 0, busy_fall_cyc = 0;
    logic go_prev = 1'b0, busy_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) run = 0;
        else if (servo) run++;
        else if (run > 0) begin
            pw_q.push_back(run);
            run = 0;
        end
        if (err) err_cnt++;
        if (drop) drop_cnt++;
        if (gate_open) go_cyc++;
        if (busy) busy_cyc++;
        if (gate_open && !go_prev) go_rise++;
        if (!gate_open && go_prev) go_fall_cyc = cyc;
        if (!busy && busy_prev) busy_fall_cyc = cyc;
        go_prev   = gate_open;
        busy_prev = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else begin
            n_pass++;
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic reset_stats();
        pw_q.delete();
        err_cnt = 0; drop_cnt = 0; go_cyc = 0; go_rise = 0; busy_cyc = 0;
        go_fall_cyc = 0; busy_fall_cyc = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    function automatic int count_w(input int w);
        int c = 0;
        foreach (pw_q[k]) if (pw_q[k] == w) c++;
        return c;
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("busy_fall_in_time", busy, 0);
        @(negedge clk);
    endtask

    task automatic run_open(input logic [7:0] a, input logic [7:0] b);
        int exp_tail[5] = '{10, 10, 10, 30, 30};
        int n;
        reset_stats();
        send_byte(a);
        send_byte(b);
        chk("busy_before_check", busy, 0);
        @(negedge clk);
        chk("arm_busy", busy, 1);
        chk("arm_gate_closed", gate_open, 0);
        wait_idle();
        chk("open_pulse_count", count_w(10), 3);
        chk("gate_open_cycles", go_cyc, 300);
        chk("gate_open_rises", go_rise, 1);
        chk("settle_cycles", busy_fall_cyc - go_fall_cyc, 200);
        n = pw_q.size();
        for (int k = 0; k < 5; k++)
            chk("pw_tail", (n >= 5) ? pw_q[n - 5 + k] : -1, exp_tail[k]);
    endtask

    initial begin
        #1;
        chk("rst_servo", servo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gate", gate_open, 0);
        chk("rst_err", err, 0);
        chk("rst_drop", drop, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        reset_stats();

        // Idle: closed-width pulses only
        repeat (500) @(negedge clk);
        chk("idle_pulse_count", pw_q.size(), 5);
        chk("idle_closed_pulses", count_w(30), 5);
        chk("idle_busy", busy_cyc, 0);
        chk("idle_gate", go_cyc, 0);
        chk("idle_err", err_cnt, 0);
        chk("idle_drop", drop_cnt, 0);

        // Valid pairs in both orders
        run_open(8'd3, 8'd103);
        run_open(8'd103, 8'd3);
        run_open(8'd12, 8'd112);

        // Invalid pair: err after 2 cycles, flags cleared
        reset_stats();
        send_byte(8'd4);
        send_byte(8'd105);
        chk("bad_err_early", err, 0);
        @(negedge clk);
        chk("bad_err_pulse", err, 1);
        chk("bad_busy", busy, 0);
        @(negedge clk);
        chk("bad_err_end", err, 0);
        send_byte(8'd5);
        repeat (200) @(negedge clk);
        chk("bad_no_open_busy", busy_cyc, 0);
        chk("bad_no_open_pw", count_w(10), 0);
        chk("bad_err_total", err_cnt, 1);
        // 5 with 106 (no bin) gives another reject and clears the pending 5
        send_byte(8'd106);
        repeat (2) @(negedge clk);
        chk("nobin_err_total", err_cnt, 2);

        // Ignored-class bytes in IDLE
        reset_stats();
        send_byte(8'd50);
        send_byte(8'd0);
        send_byte(8'd200);
        repeat (3) @(negedge clk);
        chk("ign_err", err_cnt, 0);
        chk("ign_drop", drop_cnt, 0);
        chk("ign_busy", busy_cyc, 0);

        // Byte arriving during OPEN is dropped
        reset_stats();
        send_byte(8'd3);
        send_byte(8'd103);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (gate_open) break;
        end
        chk("drop_gate_reached", gate_open, 1);
        send_byte(8'd7);
        chk("drop_pulse", drop, 1);
        @(negedge clk);
        chk("drop_pulse_end", drop, 0);
        wait_idle();
        chk("drop_total", drop_cnt, 1);
        chk("drop_open_count", count_w(10), 3);

`ifdef SERVO_SEQ_TIMEOUT_EN
        // Partial pair times out after 4 frames
        reset_stats();
        send_byte(8'd8);
        repeat (500) @(negedge clk);
        chk("to_err_count", err_cnt, 1);
        chk("to_busy", busy_cyc, 0);
        send_byte(8'd108);
        repeat (2) @(negedge clk);
        chk("to_flags_cleared", busy, 0);
`else
        // Partial pair is held indefinitely
        reset_stats();
        send_byte(8'd8);
        repeat (500) @(negedge clk);
        chk("hold_no_err", err_cnt, 0);
        send_byte(8'd108);
        @(negedge clk);
        chk("hold_pair_arms", busy, 1);
        wait_idle();
`endif

        // Reset mid-OPEN at cnt=5
        reset_stats();
        send_byte(8'd3);
        send_byte(8'd103);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (gate_open) break;
        end
        chk("rst_gate_reached", gate_open, 1);
        @(negedge clk);
        chk("rst_open_pulse_start", servo, 1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_servo", servo, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_gate", gate_open, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        reset_stats();
        repeat (300) @(negedge clk);
        chk("post_rst_pulses", pw_q.size(), 3);
        chk("post_rst_closed", count_w(30), 3);
        chk("post_rst_busy", busy_cyc, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
